// File: rtl/frac_n_ratio_ctrl.sv
// Fractional-N ratio sequencer: a MASH sigma-delta dithers the P/S load values of an 8/9 dual-modulus divider.
// One integer ratio N = 8*Pi + Si is issued per divider period; the long-run mean is cfg_nint + cfg_frac/2^F_WIDTH.
module frac_n_ratio_ctrl #(
  parameter int P_WIDTH = 5,
  parameter int S_WIDTH = 3,
  parameter int F_WIDTH = 16,
  parameter int ORDER   = 2,
  parameter int N_RST   = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [P_WIDTH+S_WIDTH-1:0] cfg_nint,
  input  logic [F_WIDTH-1:0]         cfg_frac,
  output logic [P_WIDTH-1:0]         Pi,
  output logic [S_WIDTH-1:0]         Si,
  output logic [P_WIDTH+S_WIDTH-1:0] n_out,
  output logic                       sat,
  output logic                       cfg_err
);
  localparam int NW    = P_WIDTH + S_WIDTH;
  localparam int DW    = NW + 2;
  localparam int N_MIN = 56;
  localparam int N_MAX = (1 << NW) - 1;
  localparam logic signed [DW-1:0] N_MIN_S = DW'(N_MIN);
  localparam logic signed [DW-1:0] N_MAX_S = DW'(N_MAX);
  localparam logic [NW-1:0] NINT_LO = NW'(N_MIN + 1);
  localparam logic [NW-1:0] NINT_HI = NW'(N_MAX - 2);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t state, state_next;

  logic [NW-1:0]        nint_r, n_r, n_next, n_clamped;
  logic [F_WIDTH-1:0]   frac_r, acc1, acc2;
  logic [F_WIDTH:0]     sum1, sum2;
  logic                 c1, c2, c2_d;
  logic signed [DW-1:0] d, n_eff;
  logic                 clamp, sat_next, sat_r, ready_r, err_r, accept, legal;

  // Integer parts that could push N outside [N_MIN, N_MAX] once dither is added are refused.
  assign accept = cfg_valid & ready_r;
  assign legal  = (cfg_nint >= NINT_LO) && (cfg_nint <= NINT_HI);

  always_comb begin
    sum1 = {1'b0, acc1} + {1'b0, frac_r};
    c1   = sum1[F_WIDTH];
    sum2 = {1'b0, acc2} + {1'b0, sum1[F_WIDTH-1:0]};
    c2   = sum2[F_WIDTH];
    d    = '0;
    if (ORDER == 1) begin
      d = $signed({{(DW-1){1'b0}}, c1});
    end else begin
      d = $signed({{(DW-1){1'b0}}, c1}) + $signed({{(DW-1){1'b0}}, c2})
        - $signed({{(DW-1){1'b0}}, c2_d});
    end
    n_eff     = $signed({2'b00, nint_r}) + d;
    clamp     = 1'b0;
    n_clamped = n_eff[NW-1:0];
    if (n_eff < N_MIN_S) begin
      n_clamped = NW'(N_MIN);
      clamp     = 1'b1;
    end else if (n_eff > N_MAX_S) begin
      n_clamped = NW'(N_MAX);
      clamp     = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    n_next     = nint_r;
    sat_next   = 1'b0;
    case (state)
      IDLE: if (accept && legal) state_next = LOAD;
      LOAD: state_next = (frac_r != '0) ? RUN : IDLE;
      RUN: begin
        n_next   = n_clamped;
        sat_next = clamp;
        if (accept && legal) state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // cfg_ready is registered so it stays low through the reset edge and during LOAD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nint_r  <= NW'(N_RST);
      frac_r  <= '0;
      acc1    <= '0;
      acc2    <= '0;
      c2_d    <= 1'b0;
      n_r     <= NW'(N_RST);
      sat_r   <= 1'b0;
      ready_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      ready_r <= (state_next != LOAD);
      n_r     <= n_next;
      sat_r   <= sat_next;
      if (accept) begin
        if (legal) begin
          nint_r <= cfg_nint;
          frac_r <= cfg_frac;
          err_r  <= 1'b0;
        end else begin
          err_r  <= 1'b1;
        end
      end
      case (state)
        LOAD: begin
          acc1 <= '0;
          acc2 <= '0;
          c2_d <= 1'b0;
        end
        RUN: begin
          acc1 <= sum1[F_WIDTH-1:0];
          acc2 <= (ORDER == 2) ? sum2[F_WIDTH-1:0] : '0;
          c2_d <= (ORDER == 2) ? c2 : 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign cfg_ready = ready_r;
  assign cfg_err   = err_r;
  assign sat       = sat_r;
  assign n_out     = n_r;
  assign Pi        = n_r[NW-1:S_WIDTH];
  assign Si        = n_r[S_WIDTH-1:0];

endmodule

// File: tb/tb_frac_n_ratio_ctrl.sv
// Bench for frac_n_ratio_ctrl: handshake vector table plus scoreboarded modulator runs on an
// ORDER=2 instance (u_dut) and an ORDER=1 instance (u_dut1) sharing the same stimulus.
module tb_frac_n_ratio_ctrl;
  localparam int NW = 8;

  typedef struct { int n; bit sat; } exp_t;
  typedef struct { int nint; bit err; int n_exp; } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [NW-1:0] cfg_nint = '0;
  logic [15:0]   cfg_frac = '0;

  logic          cfg_ready, sat, cfg_err;
  logic [4:0]    pi;
  logic [2:0]    si;
  logic [NW-1:0] n_out;
  logic          cfg_ready1, sat1, cfg_err1;
  logic [4:0]    pi1;
  logic [2:0]    si1;
  logic [NW-1:0] n_out1;

  exp_t exp_q[$];
  vec_t vecs[8];
  int   obs[5];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  frac_n_ratio_ctrl #(.ORDER(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_nint(cfg_nint), .cfg_frac(cfg_frac), .Pi(pi), .Si(si),
    .n_out(n_out), .sat(sat), .cfg_err(cfg_err)
  );

  frac_n_ratio_ctrl #(.ORDER(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready1),
    .cfg_nint(cfg_nint), .cfg_frac(cfg_frac), .Pi(pi1), .Si(si1),
    .n_out(n_out1), .sat(sat1), .cfg_err(cfg_err1)
  );

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Drive one configuration and return just after the edge that accepts it.
  task automatic applyStimulus(input int nint, input int frac);
    int waited = 0;
    cfg_nint  = NW'(nint);
    cfg_frac  = 16'(frac);
    cfg_valid = 1'b1;
    while (!cfg_ready && waited < 16) begin
      tick();
      waited++;
    end
    if (!cfg_ready) begin
      checkOutput("ready_wait", int'(cfg_ready), 1);
      cfg_valid = 1'b0;
      return;
    end
    tick();
    cfg_valid = 1'b0;
  endtask

  // Reference sequence: LOAD output followed by `cycles` modulator steps.
  task automatic modelPush(input int order, input int nint, input int frac, input int cycles);
    int a1 = 0;
    int a2 = 0;
    int c2d = 0;
    int c1, c2, d, n;
    exp_t e;
    e.n = nint;
    e.sat = 1'b0;
    exp_q.push_back(e);
    for (int k = 0; k < cycles; k++) begin
      a1 = a1 + frac;
      c1 = 0;
      if (a1 >= 65536) begin a1 -= 65536; c1 = 1; end
      if (order == 2) begin
        a2 = a2 + a1;
        c2 = 0;
        if (a2 >= 65536) begin a2 -= 65536; c2 = 1; end
        d = c1 + c2 - c2d;
        c2d = c2;
      end else begin
        d = c1;
      end
      n = nint + d;
      e.sat = 1'b0;
      if (n < 56) begin n = 56; e.sat = 1'b1; end
      else if (n > 255) begin n = 255; e.sat = 1'b1; end
      e.n = n;
      exp_q.push_back(e);
    end
  endtask

  task automatic checkRun(input int which, input int nint, input int frac, input int cycles,
                          input int lo, input int hi, input longint exp_sum, input int tol,
                          input bit do_mean);
    int mism = 0;
    int range_bad = 0;
    int pisi_bad = 0;
    int sat_obs = 0;
    int sat_exp = 0;
    int n, p, s, st;
    longint sum = 0;
    longint diff;
    exp_t e;
    modelPush(which, nint, frac, cycles);
    applyStimulus(nint, frac);
    for (int i = 0; i <= cycles; i++) begin
      tick();
      if (exp_q.size() == 0) begin
        checkOutput("queue_empty", 0, 1);
        break;
      end
      e  = exp_q.pop_front();
      n  = (which == 1) ? int'(n_out1) : int'(n_out);
      p  = (which == 1) ? int'(pi1) : int'(pi);
      s  = (which == 1) ? int'(si1) : int'(si);
      st = (which == 1) ? int'(sat1) : int'(sat);
      if (i < 5) begin
        obs[i] = n;
        checkOutput($sformatf("run%0d_n[%0d]", nint, i), n, e.n);
      end else if (n != e.n) begin
        mism++;
      end
      if (st != int'(e.sat)) mism++;
      if (i > 0) begin
        if (n < lo || n > hi) range_bad++;
        if (p < s) pisi_bad++;
        sat_obs += st;
        sat_exp += int'(e.sat);
        sum += n;
      end
    end
    checkOutput($sformatf("run%0d_seq_mismatches", nint), mism, 0);
    checkOutput($sformatf("run%0d_out_of_range", nint), range_bad, 0);
    checkOutput($sformatf("run%0d_pi_below_si", nint), pisi_bad, 0);
    checkOutput($sformatf("run%0d_sat_count", nint), sat_obs, sat_exp);
    if (do_mean) begin
      diff = sum - exp_sum;
      $display("[TB] run %0d: sum %0d, ideal %0d", nint, sum, exp_sum);
      checkOutput($sformatf("run%0d_mean_within_tol", nint),
                  (diff <= tol && diff >= -tol) ? 1 : 0, 1);
    end
  endtask

  initial begin
    int low_cnt;
    int bad_cnt;

    vecs[0] = '{nint: 40,  err: 1'b1, n_exp: 64};
    vecs[1] = '{nint: 80,  err: 1'b0, n_exp: 80};
    vecs[2] = '{nint: 56,  err: 1'b1, n_exp: 80};
    vecs[3] = '{nint: 57,  err: 1'b0, n_exp: 57};
    vecs[4] = '{nint: 253, err: 1'b0, n_exp: 253};
    vecs[5] = '{nint: 254, err: 1'b1, n_exp: 253};
    vecs[6] = '{nint: 255, err: 1'b1, n_exp: 253};
    vecs[7] = '{nint: 120, err: 1'b0, n_exp: 120};

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    checkOutput("rst_n_out", int'(n_out), 64);
    checkOutput("rst_pi", int'(pi), 8);
    checkOutput("rst_si", int'(si), 0);
    checkOutput("rst_ready", int'(cfg_ready), 0);
    checkOutput("rst_sat", int'(sat), 0);
    checkOutput("rst_err", int'(cfg_err), 0);
    rst_n = 1'b1;
    tick();
    checkOutput("idle_ready", int'(cfg_ready), 1);
    checkOutput("idle_n_out", int'(n_out), 64);

    // Handshake table: legal/illegal integer parts with frac = 0
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].nint, 0);
      checkOutput($sformatf("vec%0d_err", v), int'(cfg_err), int'(vecs[v].err));
      checkOutput($sformatf("vec%0d_ready", v), int'(cfg_ready), int'(vecs[v].err));
      tick();
      checkOutput($sformatf("vec%0d_n_out", v), int'(n_out), vecs[v].n_exp);
      checkOutput($sformatf("vec%0d_n_out1", v), int'(n_out1), vecs[v].n_exp);
    end

    // cfg_valid held with identical data keeps restarting the accumulators
    cfg_nint  = NW'(100);
    cfg_frac  = 16'h4000;
    cfg_valid = 1'b1;
    low_cnt = 0;
    bad_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (!cfg_ready1) low_cnt++;
      if (i > 0 && n_out1 != NW'(100)) bad_cnt++;
    end
    cfg_valid = 1'b0;
    checkOutput("held_valid_ready_low_cycles", low_cnt, 6);
    checkOutput("held_valid_n_not_100", bad_cnt, 0);

    // First-order quarter-step dither
    checkRun(1, 100, 'h4000, 4096, 100, 101, 64'd410624, 0, 1'b1);
    checkOutput("o1_pattern0", obs[0], 100);
    checkOutput("o1_pattern1", obs[1], 100);
    checkOutput("o1_pattern2", obs[2], 100);
    checkOutput("o1_pattern3", obs[3], 100);
    checkOutput("o1_pattern4", obs[4], 101);

    // MASH 1-1 over a full accumulator period
    checkRun(2, 200, 'h8001, 65536, 199, 202, 64'd13139969, 1, 1'b1);

    // Lowest legal integer part with maximum fraction
    checkRun(2, 57, 'hFFFF, 256, 56, 59, 64'd0, 0, 1'b0);

    // Reset in the middle of RUN with a pending configuration
    checkRun(2, 150, 'h1234, 20, 149, 152, 64'd0, 0, 1'b0);
    applyStimulus(40, 0);
    checkOutput("run_illegal_err", int'(cfg_err), 1);
    cfg_nint  = NW'(90);
    cfg_frac  = 16'h0000;
    cfg_valid = 1'b1;
    rst_n     = 1'b0;
    tick();
    checkOutput("midrun_rst_n_out", int'(n_out), 64);
    checkOutput("midrun_rst_n_out1", int'(n_out1), 64);
    checkOutput("midrun_rst_ready", int'(cfg_ready), 0);
    checkOutput("midrun_rst_err", int'(cfg_err), 0);
    cfg_valid = 1'b0;
    rst_n     = 1'b1;
    tick();
    checkOutput("post_rst_ready", int'(cfg_ready), 1);
    repeat (2) tick();
    checkOutput("post_rst_n_out", int'(n_out), 64);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
